vga_sync_gen: RTL and testbench
===============================

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, SHALL set the visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, SHALL set the horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, SHALL set the hsync pulse width in pixels.
REQ-004 Parameter H_BACK, default 48, SHALL set the horizontal back porch in pixels.
REQ-005 Parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, SHALL set the vertical timing in lines.
REQ-006 Port clk, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-007 Port rst, input, 1: reset SHALL be asynchronous and active-low.
REQ-008 Port pix_en, output, 1: pixel-advance strobe; counters SHALL move only when it is 1.
REQ-009 Port x_coord, output, 10: horizontal pixel counter, range 0..H_TOTAL-1.
REQ-010 Port y_coord, output, 10: vertical line counter, range 0..V_TOTAL-1.
REQ-011 Port video_on, output, 1: high when the current (x_coord,y_coord) is in the visible area.
REQ-012 Port hsync, output, 1: horizontal sync, active-low.
REQ-013 Port vsync, output, 1: vertical sync, active-low.
REQ-014 Port frame_end, output, 1: one-pixel-period pulse on the last pixel of a frame.

Function
REQ-015 H_TOTAL SHALL equal the sum of the four H parameters (default 800); V_TOTAL SHALL equal the sum of the four V parameters (default 525).
REQ-016 On each pix_en, x_coord SHALL increment by 1; at H_TOTAL-1 it SHALL wrap to 0.
REQ-017 y_coord SHALL increment by 1 only on the pix_en where x_coord wraps; at V_TOTAL-1 with x wrapping, it SHALL wrap to 0.
REQ-018 hsync SHALL be 0 iff x_coord is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], default [656,751].
REQ-019 vsync SHALL be 0 iff y_coord is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], default [490,491].
REQ-020 video_on SHALL be 1 iff x_coord<H_VISIBLE and y_coord<V_VISIBLE.
REQ-021 frame_end SHALL be 1 iff x_coord=H_TOTAL-1 and y_coord=V_TOTAL-1 and pix_en=1.
REQ-022 hsync, vsync and video_on SHALL be registered and cycle-aligned with x_coord/y_coord, with zero lag relative to the coordinates they describe.
REQ-023 Counters SHALL be 10 bits wide; values at or above H_TOTAL/V_TOTAL SHALL never be reached.
REQ-024 Outputs SHALL hold their values between pix_en strobes.

Reset
REQ-025 While rst=0: x_coord=0, y_coord=0, pix_en=0, hsync=1, vsync=1, video_on=0, frame_end=0, divider=0.
REQ-026 Reset asserted mid-frame SHALL take effect immediately, without waiting for a clock edge.
REQ-027 After rst deasserts, the first pix_en SHALL advance the counters from (0,0) to (1,0).
REQ-028 After rst deasserts, video_on SHALL track REQ-020 from the first pix_en onward.

Configuration
REQ-029 With macro VGA_PIX_DIV_EN defined, pix_en SHALL toggle every clk, giving one pixel every 2 clk cycles (50 MHz clk -> 25 MHz pixel rate).
REQ-030 With VGA_PIX_DIV_EN undefined, pix_en SHALL be 1 every clk after reset, giving one pixel per clk; no divider register SHALL exist.

Verification
REQ-031 Reset release, 1600 clk cycles with VGA_PIX_DIV_EN -> x_coord wraps 799->0 exactly once and y_coord goes 0->1.
REQ-032 Count pixels on line 0 -> hsync low for exactly 96 consecutive pixels starting at x=656; video_on high for exactly x=0..639.
REQ-033 Run a full frame -> vsync low only on lines 490 and 491; video_on is never 1 on y>=480.
REQ-034 Run a full frame -> frame_end pulses once, at (799,524), for one pixel period; the next pixel is (0,0).
REQ-035 Assert rst at (300,200), mid-frame, between clk edges -> outputs are immediately at reset values; after release, counting restarts at (0,0).
REQ-036 Build without VGA_PIX_DIV_EN -> pix_en is constantly 1 and a frame lasts 420000 clk cycles.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters plus registered, zero-lag hsync/vsync/video_on.
// Optional build macro VGA_PIX_DIV_EN: pixel strobe every second clk instead of every clk.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] x_coord,
    output logic [9:0] y_coord,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_end
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       r_pix_en;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;

    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_x_wrap;

    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        w_x_wrap = (r_x == H_MAX);
        if (r_pix_en) begin
            w_x_next = w_x_wrap ? '0 : r_x + 10'd1;
            if (w_x_wrap) begin
                w_y_next = (r_y == V_MAX) ? '0 : r_y + 10'd1;
            end
        end
    end

`ifdef VGA_PIX_DIV_EN
    // The strobe register doubles as the divide-by-two state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= ~r_pix_en;
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_en <= 1'b0;
        end else begin
            r_pix_en <= 1'b1;
        end
    end
`endif

    // Sync/blank flags are decoded from the next coordinates so they land together with them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= !((w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST));
            r_vsync    <= !((w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST));
            r_video_on <= (w_x_next < H_VIS) && (w_y_next < V_VIS);
        end
    end

    assign pix_en    = r_pix_en;
    assign x_coord   = r_x;
    assign y_coord   = r_y;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign video_on  = r_video_on;
    assign frame_end = r_pix_en && (r_x == H_MAX) && (r_y == V_MAX);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a default-timing instance for line checks and a
// small-timing instance for whole-frame, reset and randomized checks against an arithmetic model.
`timescale 1ns/1ps
module tb_vga_sync_gen;
    localparam int BHV = 8, BHF = 2, BHS = 3, BHB = 2;
    localparam int BVV = 6, BVF = 2, BVS = 2, BVB = 3;
`ifdef VGA_PIX_DIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    typedef struct packed {
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       fe;
    } obs_t;

    typedef struct {
        int   x;
        int   y;
        logic hs;
        logic vs;
        logic vo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic       a_pe, a_vo, a_hs, a_vs, a_fe;
    logic [9:0] a_x, a_y;
    logic       b_pe, b_vo, b_hs, b_vs, b_fe;
    logic [9:0] b_x, b_y;

    int n_a = 0;
    int n_b = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    vga_sync_gen dut_a (
        .clk(clk), .rst(rst_a), .pix_en(a_pe), .x_coord(a_x), .y_coord(a_y),
        .video_on(a_vo), .hsync(a_hs), .vsync(a_vs), .frame_end(a_fe)
    );

    vga_sync_gen #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB)
    ) dut_b (
        .clk(clk), .rst(rst_b), .pix_en(b_pe), .x_coord(b_x), .y_coord(b_y),
        .video_on(b_vo), .hsync(b_hs), .vsync(b_vs), .frame_end(b_fe)
    );

    always #5 clk = ~clk;

    // Clock edges elapsed since each instance left reset.
    always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) n_b <= 0; else n_b <= n_b + 1;

    // Expected outputs from the edge count alone: pixels elapsed -> (x,y) by division.
    function automatic obs_t model(bit in_rst, int n, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb);
        obs_t e;
        int ht, vt, adv, x, y;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        e = '{pe: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, fe: 1'b0};
        if (!in_rst && n > 0) begin
            adv  = (DIV == 2) ? n / 2 : n - 1;
            e.pe = (DIV == 2) ? ((n % 2) == 1) : 1'b1;
            x    = adv % ht;
            y    = (adv / ht) % vt;
            e.x  = 10'(x);
            e.y  = 10'(y);
            e.hs = !(x >= hv + hf && x < hv + hf + hsw);
            e.vs = !(y >= vv + vf && y < vv + vf + vsw);
            e.vo = (x < hv) && (y < vv);
            e.fe = e.pe && (x == ht - 1) && (y == vt - 1);
        end
        return e;
    endfunction

    function automatic obs_t model_a();
        return model(!rst_a, n_a, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b();
        return model(!rst_b, n_b, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("pe=%0b x=%0d y=%0d hs=%0b vs=%0b vo=%0b fe=%0b",
                         o.pe, o.x, o.y, o.hs, o.vs, o.vo, o.fe);
    endfunction

    task automatic check(string name, obs_t got, obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {%s} expected {%s}", name, $time, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("monitor_a", {a_pe, a_x, a_y, a_hs, a_vs, a_vo, a_fe}, model_a());
            check("monitor_b", {b_pe, b_x, b_y, b_hs, b_vs, b_vo, b_fe}, model_b());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[10];
    obs_t rst_obs, e, vexp;
    int   wraps, prev_x, hs_low, hs_first, hs_last, vo_cnt, vo_bad;
    int   fe_cnt, fe_x, fe_y, vo_bad_b, off, k;
    logic [15:0] vs_mask;
    bit   after_fe, hit;

    initial begin
        tbl[0] = '{0,   2, 1'b1, 1'b1, 1'b1};
        tbl[1] = '{639, 2, 1'b1, 1'b1, 1'b1};
        tbl[2] = '{640, 2, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{655, 2, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{656, 2, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{751, 2, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{752, 2, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{799, 2, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{0,   3, 1'b1, 1'b1, 1'b1};
        tbl[9] = '{700, 3, 1'b0, 1'b1, 1'b0};
        rst_obs = '{pe: 1'b0, x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vo: 1'b0, fe: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_a", {a_pe, a_x, a_y, a_hs, a_vs, a_vo, a_fe}, rst_obs);
        check("reset_b", {b_pe, b_x, b_y, b_hs, b_vs, b_vo, b_fe}, rst_obs);

        #2;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        mon_en = 1'b1;

        // 1600 clk after release: one x wrap, y reaches 1; line 0 sync/blank widths
        wraps = 0; prev_x = 0; hs_low = 0; hs_first = -1; hs_last = -1; vo_cnt = 0; vo_bad = 0;
        repeat (1600) begin
            @(negedge clk);
            if (prev_x == 799 && a_x == 10'd0) wraps++;
            prev_x = int'(a_x);
            if (a_pe && a_y == 10'd0) begin
                if (!a_hs) begin
                    if (hs_first < 0) hs_first = int'(a_x);
                    hs_last = int'(a_x);
                    hs_low++;
                end
                if (a_vo) begin
                    vo_cnt++;
                    if (a_x >= 10'd640) vo_bad++;
                end
            end
        end
        check_int("x_wraps_in_1600", wraps, 1);
        check_int("y_after_1600", int'(a_y), 1);
        check_int("hsync_low_count", hs_low, 96);
        check_int("hsync_first_x", hs_first, 656);
        check_int("hsync_contiguous", hs_last - hs_first + 1, hs_low);
        check_int("video_on_count_line0", vo_cnt, 640);
        check_int("video_on_outside", vo_bad, 0);

        // Table of coordinates on the default-timing instance
        for (int i = 0; i < 10; i++) begin
            hit = 1'b0;
            for (int c = 0; c < 5000; c++) begin
                @(negedge clk);
                e = model_a();
                if (e.pe && e.x == 10'(tbl[i].x) && e.y == 10'(tbl[i].y)) begin
                    hit = 1'b1;
                    break;
                end
            end
            check_int($sformatf("tbl%0d_reached", i), int'(hit), 1);
            vexp = '{pe: 1'b1, x: 10'(tbl[i].x), y: 10'(tbl[i].y),
                     hs: tbl[i].hs, vs: tbl[i].vs, vo: tbl[i].vo, fe: 1'b0};
            check($sformatf("tbl%0d", i), {a_pe, a_x, a_y, a_hs, a_vs, a_vo, a_fe}, vexp);
        end

        // Full frame on the small instance
        @(negedge clk); #2; rst_b = 1'b0;
        @(negedge clk); #2; rst_b = 1'b1;
        fe_cnt = 0; fe_x = -1; fe_y = -1; vs_mask = '0; vo_bad_b = 0; after_fe = 1'b0;
        repeat (195 * DIV + 5) begin
            @(negedge clk);
            if (after_fe) begin
                check_int("after_frame_end_x", int'(b_x), 0);
                check_int("after_frame_end_y", int'(b_y), 0);
                after_fe = 1'b0;
            end
            if (b_fe) begin
                fe_cnt++;
                fe_x = int'(b_x);
                fe_y = int'(b_y);
                after_fe = 1'b1;
            end
            if (!b_vs && b_y < 10'd16) vs_mask[b_y[3:0]] = 1'b1;
            if (b_vo && b_y >= 10'd6) vo_bad_b++;
        end
        check_int("frame_end_count", fe_cnt, 1);
        check_int("frame_end_x", fe_x, 14);
        check_int("frame_end_y", fe_y, 12);
        check_int("vsync_lines", int'(vs_mask), 32'h0300);
        check_int("video_on_below_visible", vo_bad_b, 0);

        // Asynchronous reset between clock edges, mid-frame
        hit = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            e = model_b();
            if (e.pe && e.x == 10'd7 && e.y == 10'd5) begin
                hit = 1'b1;
                break;
            end
        end
        check_int("midframe_reached", int'(hit), 1);
        #2; rst_b = 1'b0;
        #1;
        check("async_reset_now", {b_pe, b_x, b_y, b_hs, b_vs, b_vo, b_fe}, rst_obs);
        repeat (2) @(negedge clk);
        check("async_reset_held", {b_pe, b_x, b_y, b_hs, b_vs, b_vo, b_fe}, rst_obs);
        #2; rst_b = 1'b1;
        @(negedge clk);
        check_int("restart_x0", int'(b_x), 0);
        check_int("restart_y0", int'(b_y), 0);
        @(negedge clk);
        check_int("restart_x1", int'(b_x), 1);
        check_int("restart_y1", int'(b_y), 0);

        // Randomized run lengths and reset pulses at random sub-cycle offsets
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(1, 60)) @(negedge clk);
            k   = int'($urandom_range(1, 8));
            off = (k < 5) ? k : k + 1;
            #(off);
            if ($urandom_range(0, 3) == 0) rst_a = 1'b0;
            rst_b = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            k   = int'($urandom_range(1, 8));
            off = (k < 5) ? k : k + 1;
            @(negedge clk);
            #(off);
            rst_a = 1'b1;
            rst_b = 1'b1;
            @(negedge clk);
        end
        repeat (200) @(negedge clk);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
